display_arbiter: RTL and testbench
==================================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 The module SHALL have parameter SLICE_CYCLES, default 25000000, minimum ownership time-slice in clk cycles (range 2 to 2^28-1).
REQ-002 The module SHALL have parameter MAX_OWN_CYCLES, default 250000000, forced-release limit in clk cycles, used only with ARB_TIMEOUT_EN.
REQ-003 Port clk: input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 Port rst: input, 1 bit; reset is synchronous and active-low.
REQ-005 Port req: input, 3 bits, one level request per requester; the requester holds it high while it wants the display.
REQ-006 Ports data0, data1, data2: input, 32 bits each, the 8-nibble display word of requester 0/1/2.
REQ-007 Port idle_num: input, 32 bits, the word shown when no requester owns the display.
REQ-008 Port gnt: output, 3 bits, registered, one-hot or zero, current owner.
REQ-009 Port num: output, 32 bits, registered, the word driven into the 8-digit display driver.
REQ-010 Port busy: output, 1 bit, registered, high whenever gnt is non-zero.

Function
REQ-011 The FSM SHALL have states IDLE, OWN and SWITCH.
REQ-012 In IDLE: gnt=0; num<=idle_num every cycle; if any req bit is high, the next edge enters OWN with gnt set to the winner (one-cycle request-to-grant latency).
REQ-013 The winner SHALL be chosen round-robin: search starts at (last_owner+1) mod 3 and wraps; last_owner updates on every grant.
REQ-014 In OWN: num<=data of the owner every cycle (one-cycle data latency); slice counter increments from 0.
REQ-015 If the owner's req is low in OWN, the next edge SHALL enter SWITCH regardless of counter value.
REQ-016 When the slice counter reaches SLICE_CYCLES-1, owner req high and another req bit high: next edge enters SWITCH.
REQ-017 When the slice counter reaches SLICE_CYCLES-1 with no other req pending: owner keeps gnt, counter restarts at 0.
REQ-018 Owner release (REQ-015) SHALL take priority over slice expiry on the same cycle.
REQ-019 SWITCH SHALL last exactly one cycle with gnt=0, busy=0 and num holding its last value; then the round-robin winner among req bits sampled in SWITCH gets OWN, or IDLE if none.
REQ-020 Requests arriving in OWN from non-owners SHALL never cause preemption before slice expiry.
REQ-021 gnt SHALL never have more than one bit set; busy SHALL equal |gnt on every cycle.
REQ-022 Changes on data of non-owners SHALL not affect num.

Reset
REQ-023 While rst=0 at a clock edge: state<=IDLE, gnt<=0, busy<=0, num<=0, slice and timeout counters<=0, last_owner<=2 (requester 0 has first priority).
REQ-024 Reset asserted mid-ownership SHALL drop gnt on that same edge; after release, the first grant follows REQ-012 normally.

Configuration
REQ-025 Macro ARB_TIMEOUT_EN compiled in: a continuous-ownership counter runs in OWN (not cleared by slice restart); at MAX_OWN_CYCLES-1 the owner SHALL be forced to SWITCH and its req bit masked from arbitration until that bit has been sampled low once.
REQ-026 Macro ARB_TIMEOUT_EN absent: no ownership counter or mask is built; an uncontended owner keeps the display indefinitely.

Verification (SLICE_CYCLES=8, MAX_OWN_CYCLES=32)
REQ-027 rst low 2 cycles with req=3'b111 -> gnt=0, num=0, busy=0; first edge after rst high -> gnt=3'b001, next edge num=data0.
REQ-028 req=3'b011 held -> gnt alternates 001 for 8 cycles, 000 for 1 cycle, 010 for 8 cycles, repeating; num follows owner data one cycle after gnt.
REQ-029 Owner 2 drops req at slice count 3 while req0 high -> SWITCH next edge, gnt=3'b001 one cycle later; with req=0 instead -> IDLE, num=idle_num.
REQ-030 Owner req drops on the exact cycle its slice expires with others pending -> single SWITCH cycle, no extra slice granted, next owner by round-robin.
REQ-031 With ARB_TIMEOUT_EN, only req1 held high -> gnt=3'b010 for 32 cycles, SWITCH, then IDLE while req1 stays high; req1 low one cycle then high -> regranted. Without the macro -> gnt=3'b010 never drops.

Source files
------------

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin owner arbitration of a shared 8-digit display
// among three requesters, with a minimum ownership time-slice.
// Optional feature macro: ARB_TIMEOUT_EN (forced release of an owner after
// MAX_OWN_CYCLES of continuous ownership, with its request masked until it
// has been seen low once).
module display_arbiter #(
    parameter int SLICE_CYCLES   = 25000000,
    parameter int MAX_OWN_CYCLES = 250000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [31:0] idle_num,
    output logic [2:0]  gnt,
    output logic [31:0] num,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN    = 2'd1,
        SWITCH = 2'd2
    } state_t;

    localparam logic [27:0] SLICE_LAST = 28'(SLICE_CYCLES - 1);

    // Parameter sanity checks, evaluated at elaboration only.
    if (SLICE_CYCLES < 2 || SLICE_CYCLES > 268435455) begin : g_slice_range_chk
        $error("display_arbiter: SLICE_CYCLES out of range");
    end
    if (MAX_OWN_CYCLES < 2) begin : g_own_range_chk
        $error("display_arbiter: MAX_OWN_CYCLES must be at least 2");
    end

    // Round-robin pick: search starts after the last owner and wraps.
    // Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] o0;
        logic [1:0] o1;
        logic [1:0] o2;
        logic [2:0] res;
        case (last)
            2'd0: begin
                o0 = 2'd1; o1 = 2'd2; o2 = 2'd0;
            end
            2'd1: begin
                o0 = 2'd2; o1 = 2'd0; o2 = 2'd1;
            end
            default: begin
                o0 = 2'd0; o1 = 2'd1; o2 = 2'd2;
            end
        endcase
        if (r[o0]) begin
            res = {1'b1, o0};
        end else if (r[o1]) begin
            res = {1'b1, o1};
        end else if (r[o2]) begin
            res = {1'b1, o2};
        end else begin
            res = 3'b000;
        end
        return res;
    endfunction

    // Requester index to one-hot grant vector.
    function automatic logic [2:0] idx2oh(input logic [1:0] i);
        logic [2:0] oh;
        case (i)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  gnt_q, gnt_d;
    logic        busy_q, busy_d;
    logic [31:0] num_q, num_d;
    logic [27:0] slice_q, slice_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  last_q, last_d;

    logic [2:0]  req_eff_s;
    logic [2:0]  pick_s;
    logic [2:0]  owner_oh_s;
    logic        owner_req_s;
    logic [2:0]  others_s;
    logic [31:0] owner_data_s;

`ifdef ARB_TIMEOUT_EN
    localparam logic [31:0] OWN_LAST = 32'(MAX_OWN_CYCLES - 1);
    logic [31:0] own_cnt_q, own_cnt_d;
    logic [2:0]  mask_q, mask_d;
`endif

    // Effective requests, winner search and current-owner decode.
    always_comb begin
`ifdef ARB_TIMEOUT_EN
        req_eff_s = req & ~mask_q;
`else
        req_eff_s = req;
`endif
        pick_s      = rr_pick(req_eff_s, last_q);
        owner_oh_s  = idx2oh(owner_q);
        owner_req_s = |(req & owner_oh_s);
        others_s    = req_eff_s & ~owner_oh_s;
        case (owner_q)
            2'd0:    owner_data_s = data0;
            2'd1:    owner_data_s = data1;
            default: owner_data_s = data2;
        endcase
    end

    // Next-state and registered-output logic of the arbitration FSM.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        num_d   = num_q;
        slice_d = slice_q;
        owner_d = owner_q;
        last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
        own_cnt_d = own_cnt_q;
        // A mask bit is released once its request has been sampled low.
        mask_d    = mask_q & req;
`endif
        case (state_q)
            IDLE: begin
                num_d  = idle_num;
                gnt_d  = 3'b000;
                busy_d = 1'b0;
                if (pick_s[2]) begin
                    state_d = OWN;
                    gnt_d   = idx2oh(pick_s[1:0]);
                    busy_d  = 1'b1;
                    owner_d = pick_s[1:0];
                    last_d  = pick_s[1:0];
                    slice_d = 28'd0;
`ifdef ARB_TIMEOUT_EN
                    own_cnt_d = 32'd0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                num_d = owner_data_s;
`ifdef ARB_TIMEOUT_EN
                own_cnt_d = own_cnt_q + 32'd1;
`endif
                if (!owner_req_s) begin
                    // Voluntary release wins over slice expiry.
                    state_d = SWITCH;
                    gnt_d   = 3'b000;
                    busy_d  = 1'b0;
                    slice_d = 28'd0;
`ifdef ARB_TIMEOUT_EN
                end else if (own_cnt_q == OWN_LAST) begin
                    state_d = SWITCH;
                    gnt_d   = 3'b000;
                    busy_d  = 1'b0;
                    slice_d = 28'd0;
                    mask_d  = (mask_q & req) | owner_oh_s;
`endif
                end else if (slice_q == SLICE_LAST) begin
                    if (|others_s) begin
                        state_d = SWITCH;
                        gnt_d   = 3'b000;
                        busy_d  = 1'b0;
                        slice_d = 28'd0;
                    end else begin
                        // Uncontended: owner keeps the display for another slice.
                        slice_d = 28'd0;
                    end
                end else begin
                    slice_d = slice_q + 28'd1;
                end
            end
            SWITCH: begin
                // num holds its last value for the single gap cycle.
                if (pick_s[2]) begin
                    state_d = OWN;
                    gnt_d   = idx2oh(pick_s[1:0]);
                    busy_d  = 1'b1;
                    owner_d = pick_s[1:0];
                    last_d  = pick_s[1:0];
                    slice_d = 28'd0;
`ifdef ARB_TIMEOUT_EN
                    own_cnt_d = 32'd0;
`endif
                end else begin
                    state_d = IDLE;
                    gnt_d   = 3'b000;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            busy_q  <= 1'b0;
            num_q   <= 32'd0;
            slice_q <= 28'd0;
            owner_q <= 2'd0;
            last_q  <= 2'd2;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            num_q   <= num_d;
            slice_q <= slice_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Continuous-ownership counter and per-requester timeout mask.
    always_ff @(posedge clk) begin
        if (!rst) begin
            own_cnt_q <= 32'd0;
            mask_q    <= 3'b000;
        end else begin
            own_cnt_q <= own_cnt_d;
            mask_q    <= mask_d;
        end
    end
`endif

    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign num  = num_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter (SLICE_CYCLES=8, MAX_OWN_CYCLES=32).
// Table of per-edge vectors for reset/grant/release basics, plus hand-written
// sequences for slice alternation, release, expiry-release and timeout.
module tb_display_arbiter;

    localparam logic [31:0] D0   = 32'hA0A0_0000;
    localparam logic [31:0] D1   = 32'hB1B1_1111;
    localparam logic [31:0] DI   = 32'h1D1E_0E0E;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] idle_num;
    logic [2:0]  gnt;
    logic [31:0] num;
    logic        busy;

    int tests;
    int fails;

    display_arbiter #(
        .SLICE_CYCLES   (8),
        .MAX_OWN_CYCLES (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data0    (data0),
        .data1    (data1),
        .data2    (data2),
        .idle_num (idle_num),
        .gnt      (gnt),
        .num      (num),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [2:0]  req;
        logic [2:0]  gnt;
        logic        busy;
        logic [31:0] num;
    } vec_t;

    vec_t vecs[11];

    task automatic step(input logic r, input logic [2:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] eg, input logic eb, input logic [31:0] en);
        tests++;
        if (gnt !== eg || busy !== eb || num !== en) begin
            fails++;
            $display("FAIL %s: got gnt=%b busy=%b num=%h, expected gnt=%b busy=%b num=%h",
                     name, gnt, busy, num, eg, eb, en);
        end
    endtask

    task automatic do_reset();
        step(1'b0, 3'b000);
        step(1'b0, 3'b000);
    endtask

    function automatic logic [31:0] dsel(input logic [2:0] g);
        logic [31:0] d;
        case (g)
            3'b001:  d = data0;
            3'b010:  d = data1;
            3'b100:  d = data2;
            default: d = 32'hDEAD_BEEF;
        endcase
        return d;
    endfunction

    initial begin
        logic [2:0]  eg;
        logic [2:0]  pg;
        logic [31:0] en;
        logic [31:0] pn;
        logic [31:0] d2_save;

        tests    = 0;
        fails    = 0;
        rst      = 1'b0;
        req      = 3'b000;
        data0    = D0;
        data1    = D1;
        data2    = 32'hC2C2_2222;
        idle_num = DI;

        // rst, req -> gnt, busy, num after the edge
        vecs[0]  = '{1'b0, 3'b111, 3'b000, 1'b0, 32'd0};
        vecs[1]  = '{1'b0, 3'b111, 3'b000, 1'b0, 32'd0};
        vecs[2]  = '{1'b1, 3'b111, 3'b001, 1'b1, DI};
        vecs[3]  = '{1'b1, 3'b111, 3'b001, 1'b1, D0};
        vecs[4]  = '{1'b0, 3'b111, 3'b000, 1'b0, 32'd0};
        vecs[5]  = '{1'b1, 3'b000, 3'b000, 1'b0, DI};
        vecs[6]  = '{1'b1, 3'b100, 3'b100, 1'b1, DI};
        vecs[7]  = '{1'b1, 3'b100, 3'b100, 1'b1, 32'hC2C2_2222};
        vecs[8]  = '{1'b1, 3'b000, 3'b000, 1'b0, 32'hC2C2_2222};
        vecs[9]  = '{1'b1, 3'b000, 3'b000, 1'b0, 32'hC2C2_2222};
        vecs[10] = '{1'b1, 3'b000, 3'b000, 1'b0, DI};

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst_n, vecs[i].req);
            check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].busy, vecs[i].num);
        end

        // Two contenders: 8 cycles owner 0, 1 gap, 8 cycles owner 1, ...
        // Non-owner data2 toggles freely and must never reach num.
        do_reset();
        d2_save = data2;
        pg = 3'b000;
        pn = 32'd0;
        for (int k = 1; k <= 36; k++) begin
            int p;
            int blk;
            data2 = $urandom;
            step(1'b1, 3'b011);
            p   = (k - 1) % 9;
            blk = (k - 1) / 9;
            if (p == 8) eg = 3'b000;
            else if (blk % 2 == 0) eg = 3'b001;
            else eg = 3'b010;
            if (k == 1) en = DI;
            else if (pg != 3'b000) en = dsel(pg);
            else en = pn;
            check($sformatf("rr_k%0d", k), eg, |eg, en);
            pg = eg;
            pn = en;
        end
        data2 = d2_save;

        // Owner 2 releases at slice count 3 while req0 is waiting.
        do_reset();
        step(1'b1, 3'b100);
        check("rel_grant2", 3'b100, 1'b1, DI);
        for (int k = 0; k < 3; k++) step(1'b1, 3'b100);
        check("rel_own2", 3'b100, 1'b1, data2);
        step(1'b1, 3'b001);
        check("rel_switch", 3'b000, 1'b0, data2);
        step(1'b1, 3'b001);
        check("rel_grant0", 3'b001, 1'b1, data2);
        step(1'b1, 3'b001);
        check("rel_num0", 3'b001, 1'b1, D0);

        // Same release with nobody waiting -> SWITCH then IDLE.
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 3'b100);
        step(1'b1, 3'b000);
        check("rel_idle_sw", 3'b000, 1'b0, data2);
        step(1'b1, 3'b000);
        check("rel_idle_st", 3'b000, 1'b0, data2);
        step(1'b1, 3'b000);
        check("rel_idle_num", 3'b000, 1'b0, DI);

        // Owner 0 drops exactly at slice expiry; 1 and 2 waiting -> 1 wins.
        do_reset();
        for (int k = 0; k < 8; k++) step(1'b1, 3'b111);
        check("exp_last", 3'b001, 1'b1, D0);
        step(1'b1, 3'b110);
        check("exp_switch", 3'b000, 1'b0, D0);
        step(1'b1, 3'b110);
        check("exp_grant1", 3'b010, 1'b1, D0);
        step(1'b1, 3'b110);
        check("exp_num1", 3'b010, 1'b1, D1);

        // Lone requester 1 held high.
        do_reset();
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= 32; k++) begin
            step(1'b1, 3'b010);
            if (k == 1 || k == 32) check($sformatf("to_own_k%0d", k), 3'b010, 1'b1, (k == 1) ? DI : D1);
        end
        step(1'b1, 3'b010);
        check("to_switch", 3'b000, 1'b0, D1);
        step(1'b1, 3'b010);
        check("to_masked", 3'b000, 1'b0, D1);
        step(1'b1, 3'b010);
        check("to_idle", 3'b000, 1'b0, DI);
        step(1'b1, 3'b000);
        check("to_unmask", 3'b000, 1'b0, DI);
        step(1'b1, 3'b010);
        check("to_regrant", 3'b010, 1'b1, DI);
`else
        for (int k = 1; k <= 80; k++) begin
            step(1'b1, 3'b010);
            if (k == 1 || k % 10 == 0) check($sformatf("hold_k%0d", k), 3'b010, 1'b1, (k == 1) ? DI : D1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
